// File: rtl/iob_fifo2axis_rd.sv
// Drains iob_fifo_sync through its read port onto an AXI-Stream master with TLAST framing (IOB_FIFO2AXIS_RD_CNT_EN adds cnt_o).
// Latency: 2 cycles from FIFO non-empty to tvalid, then 1 word/cycle sustained.
// Backpressure: 2-entry head/skid buffer; FIFO reads are throttled so a stalled tready never overflows it.
module iob_fifo2axis_rd #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              fifo_r_en_o,
   input  logic [DATA_W-1:0] fifo_r_data_i,
   input  logic              fifo_r_empty_i,
   output logic              axis_tvalid_o,
   input  logic              axis_tready_i,
   output logic [DATA_W-1:0] axis_tdata_o,
   output logic              axis_tlast_o
`ifdef IOB_FIFO2AXIS_RD_CNT_EN
   ,
   output logic [31:0]       cnt_o
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_t;

   buf_state_t        state_q;
   logic              rd_pend;
   logic [DATA_W-1:0] head_dat;
   logic              head_last;
   logic [DATA_W-1:0] skid_dat;
   logic              skid_last;
   logic [LEN_W-1:0]  wcnt;
   logic [LEN_W-1:0]  frm_len;

   logic              pop;
   logic [2:0]        fill_nxt;
   logic [LEN_W-1:0]  eff_len;
   logic              cap_last;

   assign axis_tvalid_o = (state_q != EMPTY);
   assign axis_tdata_o  = head_dat;
   assign axis_tlast_o  = head_last;
   assign pop           = axis_tvalid_o & axis_tready_i;

   // Occupancy once the in-flight read lands and this cycle's pop retires
   assign fill_nxt    = {1'b0, state_q} + {2'b00, rd_pend} - {2'b00, pop};
   assign fifo_r_en_o = cke_i & ~rst_i & en_i & ~fifo_r_empty_i & (fill_nxt < 3'd2);

   // First word of a frame uses len_i directly since frm_len is latched in the same cycle
   assign eff_len  = (wcnt == '0) ? len_i : frm_len;
   assign cap_last = (eff_len != '0) && (wcnt == eff_len - LEN_W'(1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= EMPTY;
         rd_pend   <= 1'b0;
         head_dat  <= '0;
         head_last <= 1'b0;
         skid_dat  <= '0;
         skid_last <= 1'b0;
         wcnt      <= '0;
         frm_len   <= '0;
      end else if (cke_i) begin
         rd_pend <= fifo_r_en_o;

         if (rd_pend) begin
            if (wcnt == '0) begin
               frm_len <= len_i;
            end
            wcnt <= cap_last ? '0 : wcnt + LEN_W'(1);
         end

         case (state_q)
            EMPTY: begin
               if (rd_pend) begin
                  head_dat  <= fifo_r_data_i;
                  head_last <= cap_last;
                  state_q   <= ONE;
               end
            end
            ONE: begin
               case ({rd_pend, pop})
                  2'b10: begin
                     skid_dat  <= fifo_r_data_i;
                     skid_last <= cap_last;
                     state_q   <= TWO;
                  end
                  2'b11: begin
                     head_dat  <= fifo_r_data_i;
                     head_last <= cap_last;
                  end
                  2'b01: begin
                     state_q <= EMPTY;
                  end
                  default: begin
                     state_q <= ONE;
                  end
               endcase
            end
            TWO: begin
               // The read throttle guarantees no capture lands while both slots are full
               if (pop) begin
                  head_dat  <= skid_dat;
                  head_last <= skid_last;
                  state_q   <= ONE;
               end
            end
            default: begin
               state_q <= EMPTY;
            end
         endcase
      end
   end

`ifdef IOB_FIFO2AXIS_RD_CNT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_o <= '0;
      end else if (cke_i && pop) begin
         cnt_o <= cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_iob_fifo2axis_rd.sv
// Randomised scoreboard bench for iob_fifo2axis_rd with a behavioural FIFO and framing model.
module tb_iob_fifo2axis_rd;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              cke_i, rst_i, en_i;
   logic [LEN_W-1:0]  len_i;
   logic              fifo_r_en_o;
   logic [DATA_W-1:0] fifo_r_data_i;
   logic              fifo_r_empty_i;
   logic              axis_tvalid_o, axis_tready_i;
   logic [DATA_W-1:0] axis_tdata_o;
   logic              axis_tlast_o;
`ifdef IOB_FIFO2AXIS_RD_CNT_EN
   logic [31:0]       cnt_o;
`endif

   iob_fifo2axis_rd #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk_i          (clk),
      .cke_i          (cke_i),
      .rst_i          (rst_i),
      .en_i           (en_i),
      .len_i          (len_i),
      .fifo_r_en_o    (fifo_r_en_o),
      .fifo_r_data_i  (fifo_r_data_i),
      .fifo_r_empty_i (fifo_r_empty_i),
      .axis_tvalid_o  (axis_tvalid_o),
      .axis_tready_i  (axis_tready_i),
      .axis_tdata_o   (axis_tdata_o),
      .axis_tlast_o   (axis_tlast_o)
`ifdef IOB_FIFO2AXIS_RD_CNT_EN
      ,
      .cnt_o          (cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] fifo_q[$];
   int          vec = 0;
   int          errs = 0;
   int          pops = 0;
   int          reads = 0;
   bit          pend = 0;
   bit          rst_prev = 0;
   bit          force_empty = 0;
   logic [31:0] nd = '0;
   int          wcnt_m = 0;
   int          frm_m = 0;
   logic [31:0] acc = '0;

   bit          s_rst = 1, s_en = 1, s_rdy = 1, s_cke = 1;
   logic [15:0] s_len = 16'd4;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
      vec++;
      if (got !== expv) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, expv, $time);
      end
   endtask

   // One clock: apply shadowed stimulus at negedge, then model FIFO and framing before posedge
   task automatic cyc();
      int   held;
      bit   exp_ren;
      logic tag;
      exp_t e;
      @(negedge clk);
      rst_prev       = rst_i;
      rst_i          = s_rst;
      en_i           = s_en;
      len_i          = s_len;
      axis_tready_i  = s_rdy;
      cke_i          = s_cke;
      fifo_r_data_i  = pend ? nd : $urandom();
      fifo_r_empty_i = (fifo_q.size() == 0) || force_empty;
      #2;
      if (rst_prev) begin
         chk("rst_tvalid", 32'(axis_tvalid_o), 32'd0);
         chk("rst_tdata", axis_tdata_o, 32'd0);
         chk("rst_tlast", 32'(axis_tlast_o), 32'd0);
      end
      if (rst_i) begin
         chk("rst_rd_en", 32'(fifo_r_en_o), 32'd0);
         exp_q.delete();
         pend   = 0;
         wcnt_m = 0;
         frm_m  = 0;
      end else if (!cke_i) begin
         chk("cke_rd_en", 32'(fifo_r_en_o), 32'd0);
      end else begin
         held    = exp_q.size();
         exp_ren = en_i && !fifo_r_empty_i && (held + int'(pend) < 2);
         chk("rd_en", 32'(fifo_r_en_o), 32'(exp_ren));
         if (pend) begin
            if (wcnt_m == 0) frm_m = int'(len_i);
            tag    = (frm_m != 0) && (wcnt_m == frm_m - 1);
            wcnt_m = tag ? 0 : (wcnt_m + 1) % 65536;
            e.d = fifo_r_data_i;
            e.l = tag;
            exp_q.push_back(e);
         end
         pend = fifo_r_en_o;
         if (fifo_r_en_o) begin
            reads++;
            if (fifo_q.size() != 0) nd = fifo_q.pop_front();
         end
      end
   endtask

   // Monitor: compares every handshake against the scoreboard head
   initial begin : mon
      bit          stall;
      logic [31:0] pd;
      logic        pl;
      exp_t        m;
      stall = 0;
      pd    = '0;
      pl    = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (rst_i) begin
            stall = 0;
            acc   = '0;
         end else if (cke_i) begin
            chk("tvalid", 32'(axis_tvalid_o), 32'(exp_q.size() != 0));
`ifdef IOB_FIFO2AXIS_RD_CNT_EN
            chk("cnt_o", cnt_o, acc);
`endif
            if (stall) begin
               chk("hold_tdata", axis_tdata_o, pd);
               chk("hold_tlast", 32'(axis_tlast_o), 32'(pl));
            end
            if (axis_tvalid_o && axis_tready_i && exp_q.size() != 0) begin
               m = exp_q.pop_front();
               chk("tdata", axis_tdata_o, m.d);
               chk("tlast", 32'(axis_tlast_o), 32'(m.l));
               acc = acc + 32'd1;
               pops++;
            end
            stall = axis_tvalid_o && !axis_tready_i;
            pd    = axis_tdata_o;
            pl    = axis_tlast_o;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errs);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int t;
      int r0;
      int lens[5] = '{0, 1, 2, 3, 7};
      rst_i = 1'b1; en_i = 1'b1; len_i = 16'd4; axis_tready_i = 1'b1; cke_i = 1'b1;
      fifo_r_data_i = '0; fifo_r_empty_i = 1'b0;

      // Reset with a non-empty FIFO
      fifo_q = '{32'hAA, 32'hBB, 32'hCC};
      repeat (3) cyc();
      fifo_q.delete();

      // Straight stream, len 4, full rate
      for (int i = 0; i < 8; i++) fifo_q.push_back(32'h10 + 32'(i));
      s_rst = 0; s_len = 16'd4; s_rdy = 1;
      t = 0;
      while (pops == 0 && t < 20) begin cyc(); t++; end
      chk("t2_first_word", 32'(pops != 0), 32'd1);
      repeat (7) cyc();
      chk("t2_burst_rate", 32'(pops), 32'd8);
      repeat (4) cyc();

      // Backpressure pattern 1,0,0,1
      s_len = 16'd3;
      for (int i = 0; i < 6; i++) fifo_q.push_back(32'h30 + 32'(i));
      for (int i = 0; i < 24; i++) begin
         s_rdy = (i % 4 == 0) || (i % 4 == 3);
         cyc();
      end
      s_rdy = 1;
      repeat (4) cyc();

      // Underflow gap mid-frame, len 5
      s_len = 16'd5;
      for (int i = 0; i < 3; i++) fifo_q.push_back(32'h40 + 32'(i));
      repeat (9) cyc();
      for (int i = 3; i < 5; i++) fifo_q.push_back(32'h40 + 32'(i));
      repeat (6) cyc();

      // Enable drop after two reads, unframed
      s_len = 16'd0;
      for (int i = 0; i < 5; i++) fifo_q.push_back(32'h50 + 32'(i));
      r0 = reads;
      repeat (2) cyc();
      s_en = 0;
      chk("t5_two_reads", 32'(reads - r0), 32'd2);
      repeat (8) cyc();
      chk("t5_idle_reads", 32'(reads - r0), 32'd2);
      s_en = 1;
      repeat (8) cyc();

      // Reset mid-frame with a full buffer, then a fresh frame
      s_len = 16'd4;
      for (int i = 0; i < 10; i++) fifo_q.push_back(32'h60 + 32'(i));
      s_rdy = 0;
      repeat (4) cyc();
      s_rst = 1;
      cyc();
      s_rst = 0; s_rdy = 1;
      cyc();
      s_rst = 1;
      cyc();
      s_rst = 0;
      repeat (12) cyc();

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         if (fifo_q.size() < 4 && $urandom_range(0, 3) == 0) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) fifo_q.push_back($urandom());
         end
         s_rdy       = ($urandom_range(0, 9) < 7);
         s_en        = ($urandom_range(0, 9) != 0);
         force_empty = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) s_len = 16'(lens[$urandom_range(0, 4)]);
         s_rst = ($urandom_range(0, 149) == 0);
         s_cke = s_rst ? 1'b1 : ($urandom_range(0, 19) != 0);
         if (!s_cke) s_rdy = 0;
         cyc();
      end

      // Drain everything still queued
      s_rst = 0; s_en = 1; s_rdy = 1; s_cke = 1; force_empty = 0;
      t = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || pend) && t < 300) begin
         cyc();
         t++;
      end
      chk("drain_empty", 32'(exp_q.size() + fifo_q.size()), 32'd0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
